// File: rtl/rs_dec_pkg.sv
// Shared definitions for the RS(255,251) decoder key-equation arbitration.
// Holds the syndrome geometry defaults, the arbiter FSM encoding and a
// helper that sizes lane-index fields.
package rs_dec_pkg;

  localparam int SYN_W_DEF = 8;  // GF(2^8) symbol width
  localparam int NSYN_DEF  = 4;  // 2t syndromes for RS(255,251)

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Width of a lane index; never narrower than one bit
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs_euclid_arb_rr_arbiter.sv
// Combinational round-robin picker.
// Searches req starting at the lane after ptr and wrapping around, so the
// lane at ptr itself has the lowest priority.
// Ports:
//   req      in   NUM_LANES  request vector
//   ptr      in   LANE_W     last granted lane
//   gnt_idx  out  LANE_W     picked lane (0 when nothing requests)
//   any      out  1          at least one request present
module rr_arbiter
  import rs_dec_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = lane_w(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [LANE_W-1:0]    ptr,
  output logic [LANE_W-1:0]    gnt_idx,
  output logic                 any
);

  logic [LANE_W-1:0] idx_s;
  logic              hit_s;

  // Walk lanes ptr+1 .. ptr+NUM_LANES (mod NUM_LANES); the first request wins
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx_s   = LANE_W'((int'(ptr) + k) % NUM_LANES);
      hit_s   = req[idx_s] & ~any;
      gnt_idx = hit_s ? idx_s : gnt_idx;
      any     = any | hit_s;
    end
  end

endmodule

// File: rtl/rs_euclid_arb.sv
// Time-shares one Euclid key-equation solver among NUM_LANES syndrome lanes.
// Each lane owns a one-deep holding slot. Non-zero syndrome sets are granted
// to the solver in round-robin order; all-zero sets bypass the solver and are
// reported directly. At most one result strobe is produced per cycle.
// Optional feature: define RS_ARB_WDOG_EN to add a WAIT watchdog that ends a
// solver run after WDOG_CYCLES cycles with res_fail=1.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   syn_valid     in   per-lane syndrome set valid
//   syn_zero      in   per-lane all-zero flag
//   syn_data      in   per-lane syndromes, lane i in slice i
//   syn_ready     out  per-lane slot empty
//   euclid_start  out  one-cycle solver start pulse
//   euclid_syn    out  syndromes of the granted lane (held START..DONE)
//   euclid_ok     in   one-cycle solver completion pulse
//   res_valid     out  one-cycle result strobe
//   res_lane      out  lane owning the result
//   res_bypass    out  result is a zero-syndrome bypass
//   res_fail      out  solver timed out (watchdog build only)
module rs_euclid_arb
  import rs_dec_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int SYN_W       = SYN_W_DEF,
  parameter int NSYN        = NSYN_DEF,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LANES-1:0]            syn_valid,
  input  logic [NUM_LANES-1:0]            syn_zero,
  input  logic [NUM_LANES*NSYN*SYN_W-1:0] syn_data,
  output logic [NUM_LANES-1:0]            syn_ready,
  output logic                            euclid_start,
  output logic [NSYN*SYN_W-1:0]           euclid_syn,
  input  logic                            euclid_ok,
  output logic                            res_valid,
  output logic [lane_w(NUM_LANES)-1:0]    res_lane,
  output logic                            res_bypass,
  output logic                            res_fail
);

  localparam int LANE_W = lane_w(NUM_LANES);
  localparam int SET_W  = NSYN * SYN_W;

  logic [NUM_LANES-1:0]            slot_full_r;
  logic [NUM_LANES-1:0]            slot_zero_r;
  logic [NUM_LANES-1:0][SET_W-1:0] slot_data_r;
  logic [NUM_LANES-1:0]            slot_clr_s;

  arb_state_e        state_r;
  logic [LANE_W-1:0] grant_r;
  logic [LANE_W-1:0] rr_ptr_r;
  logic [SET_W-1:0]  euclid_syn_r;

  logic [NUM_LANES-1:0] elig_req_s;
  logic [LANE_W-1:0]    elig_idx_s;
  logic                 elig_any_s;
  logic [LANE_W-1:0]    byp_idx_s;
  logic                 byp_any_s;
  logic                 byp_fire_s;
  logic                 done_s;

`ifdef RS_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt_r;
  logic              fail_r;
`endif

  assign elig_req_s = slot_full_r & ~slot_zero_r;
  assign done_s     = (state_r == ST_DONE);

  rr_arbiter #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_rr_arbiter (
    .req     (elig_req_s),
    .ptr     (rr_ptr_r),
    .gnt_idx (elig_idx_s),
    .any     (elig_any_s)
  );

  // Fixed-priority bypass pick: scanning downward leaves the lowest index
  always_comb begin
    byp_idx_s = '0;
    byp_any_s = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (slot_full_r[i] && slot_zero_r[i]) begin
        byp_idx_s = LANE_W'(i);
        byp_any_s = 1'b1;
      end else begin
        byp_idx_s = byp_idx_s;
        byp_any_s = byp_any_s;
      end
    end
  end

  // A bypass yields to DONE so only one result leaves per cycle
  assign byp_fire_s = byp_any_s & ~done_s;

  // Slot release: granted slot in DONE, bypass slot when it fires
  always_comb begin
    slot_clr_s = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      slot_clr_s[i] = (done_s && (grant_r == LANE_W'(i))) ||
                      (byp_fire_s && (byp_idx_s == LANE_W'(i)));
    end
  end

  // Per-lane holding slots: capture on handshake, release on result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_full_r <= '0;
      slot_zero_r <= '0;
      slot_data_r <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (syn_valid[i] && !slot_full_r[i]) begin
          slot_full_r[i] <= 1'b1;
          slot_zero_r[i] <= syn_zero[i];
          slot_data_r[i] <= syn_data[i*SET_W +: SET_W];
        end else if (slot_clr_s[i]) begin
          slot_full_r[i] <= 1'b0;
        end
      end
    end
  end

  // Solver sequencing: grant, start, wait for completion, report
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      rr_ptr_r     <= LANE_W'(NUM_LANES - 1);
      euclid_syn_r <= '0;
`ifdef RS_ARB_WDOG_EN
      wdog_cnt_r   <= '0;
      fail_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (elig_any_s) begin
            grant_r      <= elig_idx_s;
            euclid_syn_r <= slot_data_r[elig_idx_s];
            state_r      <= ST_START;
          end
        end
        ST_START: begin
`ifdef RS_ARB_WDOG_EN
          wdog_cnt_r <= '0;
`endif
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (euclid_ok) begin
            state_r <= ST_DONE;
`ifdef RS_ARB_WDOG_EN
          end else if (wdog_cnt_r == WDOG_W'(WDOG_CYCLES - 1)) begin
            // WDOG_CYCLES WAIT cycles elapsed without completion
            fail_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
`endif
          end
        end
        ST_DONE: begin
          rr_ptr_r <= grant_r;
`ifdef RS_ARB_WDOG_EN
          fail_r   <= 1'b0;
`endif
          state_r  <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // All outputs are decoded from registers only
  assign syn_ready    = ~slot_full_r;
  assign euclid_start = (state_r == ST_START);
  assign euclid_syn   = euclid_syn_r;
  assign res_valid    = done_s | byp_fire_s;
  assign res_bypass   = byp_fire_s;
  assign res_lane     = done_s ? grant_r : byp_idx_s;
`ifdef RS_ARB_WDOG_EN
  assign res_fail     = done_s & fail_r;
`else
  assign res_fail     = 1'b0;
`endif

endmodule

// File: tb/tb_rs_euclid_arb.sv
// Directed self-checking bench for rs_euclid_arb (4 lanes, 8-bit symbols,
// 4 syndromes). Inputs change 1 ns after the rising edge; outputs are
// sampled at that point too, well away from the next edge.
// The watchdog scenario runs only when RS_ARB_WDOG_EN is defined.
module tb_rs_euclid_arb;

  localparam int NL    = 4;
  localparam int SET_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NL-1:0]     syn_valid;
  logic [NL-1:0]     syn_zero;
  logic [NL*32-1:0]  syn_data;
  logic [NL-1:0]     syn_ready;
  logic              euclid_start;
  logic [31:0]       euclid_syn;
  logic              euclid_ok;
  logic              res_valid;
  logic [1:0]        res_lane;
  logic              res_bypass;
  logic              res_fail;

  int checks    = 0;
  int errors    = 0;
  int start_cnt = 0;
  int res_cnt   = 0;

  rs_euclid_arb #(
    .NUM_LANES   (NL),
    .SYN_W       (8),
    .NSYN        (4),
    .WDOG_CYCLES (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .syn_valid    (syn_valid),
    .syn_zero     (syn_zero),
    .syn_data     (syn_data),
    .syn_ready    (syn_ready),
    .euclid_start (euclid_start),
    .euclid_syn   (euclid_syn),
    .euclid_ok    (euclid_ok),
    .res_valid    (res_valid),
    .res_lane     (res_lane),
    .res_bypass   (res_bypass),
    .res_fail     (res_fail)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Count solver starts and result strobes outside reset
  always @(negedge clk) begin
    if (!rst) begin
      if (euclid_start) start_cnt <= start_cnt + 1;
      if (res_valid)    res_cnt   <= res_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Distinct non-zero syndrome pattern per lane and tag
  function automatic logic [31:0] ld(input int l, input int v);
    logic [7:0] b;
    b = 8'(l * 16 + v + 1);
    return {b, b ^ 8'h5A, b ^ 8'hA5, ~b};
  endfunction

  task automatic put(input int l, input logic [31:0] d, input logic z);
    syn_valid[l]           = 1'b1;
    syn_zero[l]            = z;
    syn_data[l*32 +: 32]   = d;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    syn_valid = '0;
    syn_zero  = '0;
    syn_data  = '0;
    euclid_ok = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_start(input int limit, output int n);
    n = 0;
    while (euclid_start !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check("start_seen", 64'(euclid_start), 64'd1);
  endtask

  int s0;
  int r0;
  int n;

  initial begin
    rst       = 1'b1;
    syn_valid = '0;
    syn_zero  = '0;
    syn_data  = '0;
    euclid_ok = 1'b0;
    tick();
    tick();
    // ---- reset state ----
    check("rst_ready",  64'(syn_ready),    64'hF);
    check("rst_start",  64'(euclid_start), 64'd0);
    check("rst_valid",  64'(res_valid),    64'd0);
    check("rst_lane",   64'(res_lane),     64'd0);
    check("rst_bypass", 64'(res_bypass),   64'd0);
    check("rst_fail",   64'(res_fail),     64'd0);
    check("rst_syn",    64'(euclid_syn),   64'd0);
    rst = 1'b0;
    tick();

    // ---- single lane: handshake N, START N+2, ok N+12, DONE N+13 ----
    s0 = start_cnt;
    put(0, ld(0, 0), 1'b0);
    check("t1_hs_ready", 64'(syn_ready[0]), 64'd1);
    tick();
    syn_valid = '0;
    check("t1_full",    64'(syn_ready),    64'hE);
    check("t1_nostart", 64'(euclid_start), 64'd0);
    tick();
    check("t1_start", 64'(euclid_start), 64'd1);
    check("t1_syn",   64'(euclid_syn),   64'(ld(0, 0)));
    repeat (10) tick();
    check("t1_wait_nores", 64'(res_valid), 64'd0);
    euclid_ok = 1'b1;
    tick();
    euclid_ok = 1'b0;
    check("t1_done_valid",  64'(res_valid),  64'd1);
    check("t1_done_lane",   64'(res_lane),   64'd0);
    check("t1_done_bypass", 64'(res_bypass), 64'd0);
    check("t1_done_ready",  64'(syn_ready),  64'hE);
    tick();
    check("t1_after_valid", 64'(res_valid), 64'd0);
    check("t1_after_ready", 64'(syn_ready), 64'hF);
    check("t1_start_count", 64'(start_cnt - s0), 64'd1);

    // ---- all four lanes at once: grants 0,1,2,3 ----
    do_reset();
    for (int i = 0; i < NL; i++) put(i, ld(i, 1), 1'b0);
    tick();
    syn_valid = '0;
    r0 = res_cnt;
    for (int k = 0; k < NL; k++) begin
      wait_start(10, n);
      check("t2_gap", 64'(n), (k == 0) ? 64'd1 : 64'd2);
      check("t2_syn_start", 64'(euclid_syn), 64'(ld(k, 1)));
      repeat (5) tick();
      check("t2_syn_wait", 64'(euclid_syn), 64'(ld(k, 1)));
      euclid_ok = 1'b1;
      tick();
      euclid_ok = 1'b0;
      check("t2_valid",  64'(res_valid),  64'd1);
      check("t2_lane",   64'(res_lane),   64'(k));
      check("t2_bypass", 64'(res_bypass), 64'd0);
    end
    tick();
    tick();
    check("t2_res_count", 64'(res_cnt - r0), 64'd4);
    check("t2_ready",     64'(syn_ready),    64'hF);

    // ---- bypass during WAIT, then bypass colliding with DONE ----
    s0 = start_cnt;
    put(0, ld(0, 2), 1'b0);
    tick();
    syn_valid = '0;
    tick();
    check("t3_start", 64'(euclid_start), 64'd1);
    tick();
    put(2, 32'h0, 1'b1);
    tick();
    syn_valid = '0;
    check("t3_byp_valid",  64'(res_valid),    64'd1);
    check("t3_byp_bypass", 64'(res_bypass),   64'd1);
    check("t3_byp_lane",   64'(res_lane),     64'd2);
    check("t3_byp_nostart", 64'(euclid_start), 64'd0);
    tick();
    check("t3_byp_clear", 64'(res_valid), 64'd0);
    check("t3_ready",     64'(syn_ready), 64'hE);
    euclid_ok = 1'b1;
    put(3, 32'h0, 1'b1);
    tick();
    euclid_ok = 1'b0;
    syn_valid = '0;
    check("t3_done_valid",  64'(res_valid),  64'd1);
    check("t3_done_bypass", 64'(res_bypass), 64'd0);
    check("t3_done_lane",   64'(res_lane),   64'd0);
    check("t3_done_ready",  64'(syn_ready),  64'h6);
    tick();
    check("t3_def_valid",  64'(res_valid),    64'd1);
    check("t3_def_bypass", 64'(res_bypass),   64'd1);
    check("t3_def_lane",   64'(res_lane),     64'd3);
    check("t3_def_nostart", 64'(euclid_start), 64'd0);
    tick();
    check("t3_end_valid",  64'(res_valid),        64'd0);
    check("t3_end_ready",  64'(syn_ready),        64'hF);
    check("t3_start_count", 64'(start_cnt - s0), 64'd1);

    // ---- lane 1 held valid while slot full; ok during START ignored ----
    put(1, ld(1, 3), 1'b0);
    tick();
    put(1, ld(1, 4), 1'b0);
    check("t4_blocked", 64'(syn_ready[1]), 64'd0);
    tick();
    check("t4_start",   64'(euclid_start), 64'd1);
    check("t4_syn_old", 64'(euclid_syn),   64'(ld(1, 3)));
    euclid_ok = 1'b1;
    tick();
    euclid_ok = 1'b0;
    check("t4_ok_ignored", 64'(res_valid),    64'd0);
    check("t4_in_wait",    64'(euclid_start), 64'd0);
    euclid_ok = 1'b1;
    tick();
    euclid_ok = 1'b0;
    check("t4_done_valid", 64'(res_valid),    64'd1);
    check("t4_done_lane",  64'(res_lane),     64'd1);
    check("t4_done_ready", 64'(syn_ready[1]), 64'd0);
    tick();
    check("t4_released", 64'(syn_ready[1]), 64'd1);
    tick();
    syn_valid = '0;
    check("t4_recaptured", 64'(syn_ready[1]), 64'd0);
    tick();
    check("t4_start2",  64'(euclid_start), 64'd1);
    check("t4_syn_new", 64'(euclid_syn),   64'(ld(1, 4)));
    tick();
    euclid_ok = 1'b1;
    tick();
    euclid_ok = 1'b0;
    check("t4_done2_lane", 64'(res_lane), 64'd1);
    tick();

`ifdef RS_ARB_WDOG_EN
    // ---- watchdog: no euclid_ok, fail after 64 WAIT cycles ----
    do_reset();
    put(0, ld(0, 5), 1'b0);
    put(1, ld(1, 5), 1'b0);
    tick();
    syn_valid = '0;
    wait_start(10, n);
    repeat (64) tick();
    check("t5_last_wait", 64'(res_valid), 64'd0);
    tick();
    check("t5_valid",  64'(res_valid),  64'd1);
    check("t5_fail",   64'(res_fail),   64'd1);
    check("t5_lane",   64'(res_lane),   64'd0);
    check("t5_bypass", 64'(res_bypass), 64'd0);
    tick();
    check("t5_freed", 64'(syn_ready[0]), 64'd1);
    tick();
    check("t5_next_start", 64'(euclid_start), 64'd1);
    check("t5_next_syn",   64'(euclid_syn),   64'(ld(1, 5)));
    tick();
    euclid_ok = 1'b1;
    tick();
    euclid_ok = 1'b0;
    check("t5_next_lane", 64'(res_lane), 64'd1);
    check("t5_next_fail", 64'(res_fail), 64'd0);
    tick();
`endif

    // ---- reset mid-WAIT with three slots full ----
    do_reset();
    for (int i = 0; i < 3; i++) put(i, ld(i, 6), 1'b0);
    tick();
    syn_valid = '0;
    wait_start(10, n);
    tick();
    r0 = res_cnt;
    rst = 1'b1;
    tick();
    check("t6_ready", 64'(syn_ready),    64'hF);
    check("t6_start", 64'(euclid_start), 64'd0);
    check("t6_valid", 64'(res_valid),    64'd0);
    check("t6_syn",   64'(euclid_syn),   64'd0);
    rst = 1'b0;
    tick();
    tick();
    check("t6_no_result", 64'(res_cnt - r0), 64'd0);
    put(2, ld(2, 7), 1'b0);
    put(1, ld(1, 7), 1'b0);
    put(0, ld(0, 7), 1'b0);
    tick();
    syn_valid = '0;
    wait_start(10, n);
    check("t6_first_syn", 64'(euclid_syn), 64'(ld(0, 7)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
